// File: rtl/led_chase_ctrl_pkg.sv
// led_chase_ctrl_pkg: state encoding, direction constants and default step period for the LED chaser.
package led_chase_ctrl_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DOWN = 1'b1;
   localparam int unsigned DEFAULT_CLK_DIV = 100_000_000;
endpackage

// File: rtl/led_chase_ctrl_tick_gen.sv
// tick_gen: prescaler counting 0..DIV-1 while enabled, freezing when disabled, with a one-cycle tick at DIV-1.
module tick_gen
   import led_chase_ctrl_pkg::*;
#(
   parameter int unsigned DIV = DEFAULT_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int W = $clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);
   logic [W-1:0] cnt;
   assign tick = en && cnt == LAST;
   always_ff @(posedge clk) begin
      if (reset || clr) cnt <= '0;
      else if (en) cnt <= tick ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/led_chase_ctrl.sv
// led_chase_ctrl: start/stop/clear LED chaser stepping ledIdx 1..LAST_IDX every CLK_DIV cycles.
// Define LED_CHASE_BOUNCE_EN to ping-pong instead of wrapping.
module led_chase_ctrl
   import led_chase_ctrl_pkg::*;
#(
   parameter int unsigned CLK_DIV  = DEFAULT_CLK_DIV,
   parameter int unsigned LAST_IDX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       startBtn,
   input  logic       stopBtn,
   input  logic       clearBtn,
   output logic [3:0] ledIdx,
   output logic       running,
   output logic       wrapPulse
);
   localparam logic [3:0] TOP = 4'(LAST_IDX);
   state_t state, state_n;
   logic [3:0] led_n;
   logic wrap_n, run_en, tick, start;
   // a stop on a tick cycle disables the prescaler, so it freezes at DIV-1 and the step is not taken
   assign run_en = state == RUN && !clearBtn && !stopBtn;
   assign start = state == IDLE && state_n == RUN;
   tick_gen #(.DIV(CLK_DIV)) u_tick (
      .clk(clk),
      .reset(reset),
      .en(run_en),
      .clr(clearBtn),
      .tick(tick)
   );
   always_comb begin
      state_n = state;
      if (clearBtn) state_n = IDLE;
      else if (stopBtn) state_n = state == RUN ? PAUSE : state;
      else if (startBtn && state != RUN) state_n = RUN;
   end
`ifdef LED_CHASE_BOUNCE_EN
   logic dir, dir_n;
   always_comb begin
      dir_n = dir;
      led_n = ledIdx;
      wrap_n = 1'b0;
      if (clearBtn || start) begin
         led_n = clearBtn ? 4'd0 : 4'd1;
         dir_n = DIR_UP;
      end else if (tick) begin
         if (dir == DIR_UP && ledIdx == TOP) begin
            led_n = TOP - 4'd1;
            dir_n = DIR_DOWN;
         end else if (dir == DIR_DOWN && ledIdx == 4'd2) begin
            led_n = 4'd1;
            dir_n = DIR_UP;
            wrap_n = 1'b1;
         end else led_n = dir == DIR_UP ? ledIdx + 4'd1 : ledIdx - 4'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) dir <= DIR_UP;
      else dir <= dir_n;
   end
`else
   always_comb begin
      led_n = ledIdx;
      wrap_n = 1'b0;
      if (clearBtn) led_n = 4'd0;
      else if (start) led_n = 4'd1;
      else if (tick) begin
         wrap_n = ledIdx == TOP;
         led_n = wrap_n ? 4'd1 : ledIdx + 4'd1;
      end
   end
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ledIdx <= '0;
         running <= 1'b0;
         wrapPulse <= 1'b0;
      end else begin
         state <= state_n;
         ledIdx <= led_n;
         running <= state_n == RUN;
         wrapPulse <= wrap_n;
      end
   end
endmodule

// File: tb/tb_led_chase_ctrl.sv
// tb_led_chase_ctrl: directed checks of the LED chaser with CLK_DIV=4, LAST_IDX=15.
module tb_led_chase_ctrl;
   logic clk = 1'b0, reset = 1'b0, startBtn = 1'b0, stopBtn = 1'b0, clearBtn = 1'b0;
   logic [3:0] ledIdx;
   logic running, wrapPulse;
   int passed = 0, total = 0;

   led_chase_ctrl #(.CLK_DIV(4), .LAST_IDX(15)) dut (
      .clk(clk), .reset(reset), .startBtn(startBtn), .stopBtn(stopBtn),
      .clearBtn(clearBtn), .ledIdx(ledIdx), .running(running), .wrapPulse(wrapPulse)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fresh_start();
      clearBtn = 1'b1;
      step();
      clearBtn = 1'b0;
      startBtn = 1'b1;
      step();
      startBtn = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      total++; if (ledIdx !== 4'd0) $display("FAIL reset_led: got %0d expected 0", ledIdx); else passed++;
      total++; if (running !== 1'b0) $display("FAIL reset_running: got %b expected 0", running); else passed++;
      total++; if (wrapPulse !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", wrapPulse); else passed++;
      stopBtn = 1'b1;
      step();
      stopBtn = 1'b0;
      total++; if (ledIdx !== 4'd0 || running !== 1'b0) $display("FAIL idle_stop_ignored: led %0d running %b expected 0 0", ledIdx, running); else passed++;
   endtask

   task automatic test_start();
      startBtn = 1'b1;
      step();
      startBtn = 1'b0;
      total++; if (ledIdx !== 4'd1) $display("FAIL start_led1: got %0d expected 1", ledIdx); else passed++;
      total++; if (running !== 1'b1) $display("FAIL start_running: got %b expected 1", running); else passed++;
      startBtn = 1'b1;
      step(3);
      startBtn = 1'b0;
      total++; if (ledIdx !== 4'd1) $display("FAIL before_tick: got %0d expected 1", ledIdx); else passed++;
      step();
      total++; if (ledIdx !== 4'd2) $display("FAIL first_tick: got %0d expected 2", ledIdx); else passed++;
      step(4);
      total++; if (ledIdx !== 4'd3) $display("FAIL second_tick: got %0d expected 3", ledIdx); else passed++;
   endtask

`ifndef LED_CHASE_BOUNCE_EN
   task automatic test_wrap();
      int wraps = 0;
      logic [3:0] exp_led;
      fresh_start();
      for (int c = 1; c <= 60; c++) begin
         step();
         if (wrapPulse) wraps++;
         if (c % 4 == 0) begin
            exp_led = (c == 60) ? 4'd1 : 4'(c / 4 + 1);
            total++; if (ledIdx !== exp_led) $display("FAIL wrap_seq c%0d: got %0d expected %0d", c, ledIdx, exp_led); else passed++;
            total++; if (wrapPulse !== (c == 60)) $display("FAIL wrap_pulse c%0d: got %b expected %b", c, wrapPulse, c == 60); else passed++;
         end
      end
      step();
      if (wrapPulse) wraps++;
      total++; if (wraps !== 1) $display("FAIL wrap_count: got %0d expected 1", wraps); else passed++;
   endtask
`else
   task automatic test_bounce();
      int wraps = 0;
      logic [3:0] exp_led;
      fresh_start();
      for (int k = 1; k <= 30; k++) begin
         step(4);
         if (wrapPulse) wraps++;
         exp_led = k <= 14 ? 4'(k + 1) : k <= 28 ? 4'(29 - k) : 4'(k - 27);
         total++; if (ledIdx !== exp_led) $display("FAIL bounce_seq k%0d: got %0d expected %0d", k, ledIdx, exp_led); else passed++;
         total++; if (wrapPulse !== (k == 28)) $display("FAIL bounce_pulse k%0d: got %b expected %b", k, wrapPulse, k == 28); else passed++;
      end
      total++; if (wraps !== 1) $display("FAIL bounce_wrap_count: got %0d expected 1", wraps); else passed++;
   endtask
`endif

   task automatic test_stop_on_tick();
      fresh_start();
      step(19);
      total++; if (ledIdx !== 4'd5) $display("FAIL pre_stop_led: got %0d expected 5", ledIdx); else passed++;
      stopBtn = 1'b1;
      step();
      stopBtn = 1'b0;
      total++; if (ledIdx !== 4'd5 || running !== 1'b0) $display("FAIL stop_tick: led %0d running %b expected 5 0", ledIdx, running); else passed++;
      for (int i = 0; i < 20; i++) begin
         step();
         total++; if (ledIdx !== 4'd5) $display("FAIL pause_hold %0d: got %0d expected 5", i, ledIdx); else passed++;
      end
      startBtn = 1'b1;
      step();
      startBtn = 1'b0;
      total++; if (ledIdx !== 4'd5 || running !== 1'b1) $display("FAIL resume: led %0d running %b expected 5 1", ledIdx, running); else passed++;
      step();
      total++; if (ledIdx !== 4'd6) $display("FAIL resume_tick: got %0d expected 6", ledIdx); else passed++;
   endtask

   task automatic test_clear_start_in_pause();
      stopBtn = 1'b1;
      step();
      stopBtn = 1'b0;
      total++; if (running !== 1'b0 || ledIdx !== 4'd6) $display("FAIL enter_pause: led %0d running %b expected 6 0", ledIdx, running); else passed++;
      clearBtn = 1'b1;
      startBtn = 1'b1;
      step();
      clearBtn = 1'b0;
      startBtn = 1'b0;
      total++; if (ledIdx !== 4'd0) $display("FAIL clear_led: got %0d expected 0", ledIdx); else passed++;
      total++; if (running !== 1'b0) $display("FAIL clear_running: got %b expected 0", running); else passed++;
      step(6);
      total++; if (ledIdx !== 4'd0 || running !== 1'b0) $display("FAIL idle_hold: led %0d running %b expected 0 0", ledIdx, running); else passed++;
   endtask

   task automatic test_reset_mid_run();
      fresh_start();
      step(59);
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++; if (ledIdx !== 4'd0 || running !== 1'b0) $display("FAIL reset_mid: led %0d running %b expected 0 0", ledIdx, running); else passed++;
      total++; if (wrapPulse !== 1'b0) $display("FAIL reset_mid_wrap: got %b expected 0", wrapPulse); else passed++;
      startBtn = 1'b1;
      step();
      startBtn = 1'b0;
      step(4);
      total++; if (ledIdx !== 4'd2) $display("FAIL restart_tick: got %0d expected 2", ledIdx); else passed++;
   endtask

   initial begin
      test_reset();
      test_start();
`ifndef LED_CHASE_BOUNCE_EN
      test_wrap();
`else
      test_bounce();
`endif
      test_stop_on_tick();
      test_clear_start_in_pause();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
